seg_scan_capture: RTL and testbench

Receive-side monitor for the 8-digit multiplexed seven-segment bus. It observes active-low anode selects and active-low segment/decimal-point lines, and waits for each pattern to hold stable for a programmable number of clocks. It then decodes the lit glyph back to a 4-bit hex value and stores it per digit. It sits beside the display driver and gives logic and benches a readable copy of what the display shows.

---
 rtl/seg_scan_capture.sv | 198 +++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// Receive-side monitor for an 8-digit multiplexed seven-segment bus: debounces {AN,SEG,DP}, decodes glyphs per digit.
// Optional feature macro: SEG_SCAN_CAPTURE_DP_EN (decimal point joins the stability compare and is captured).
module seg_scan_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  AN,
  input  logic [6:0]  SEG,
  input  logic        DP,
  output logic [31:0] DIGITS,
  output logic [7:0]  VALID,
  output logic [7:0]  DP_OUT,
  output logic        FRAME,
  output logic [7:0]  ERR_CNT,
  output logic        BAD_SEG
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] COMMIT_AT  = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    AN_IDLE    = 2'd0,
    AN_SINGLE  = 2'd1,
    AN_ILLEGAL = 2'd2
  } an_class_e;

  // Active-low glyph table; returns {hit, value}.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h40:   res = {1'b1, 4'h0};
      7'h79:   res = {1'b1, 4'h1};
      7'h24:   res = {1'b1, 4'h2};
      7'h30:   res = {1'b1, 4'h3};
      7'h19:   res = {1'b1, 4'h4};
      7'h12:   res = {1'b1, 4'h5};
      7'h02:   res = {1'b1, 4'h6};
      7'h78:   res = {1'b1, 4'h7};
      7'h00:   res = {1'b1, 4'h8};
      7'h10:   res = {1'b1, 4'h9};
      7'h08:   res = {1'b1, 4'hA};
      7'h03:   res = {1'b1, 4'hB};
      7'h46:   res = {1'b1, 4'hC};
      7'h21:   res = {1'b1, 4'hD};
      7'h06:   res = {1'b1, 4'hE};
      7'h0E:   res = {1'b1, 4'hF};
      default: res = 5'b0;
    endcase
    return res;
  endfunction

  logic [7:0]  samp_an_q,  samp_an_d;
  logic [6:0]  samp_seg_q, samp_seg_d;
  logic [7:0]  cnt_q,      cnt_d;
  logic [31:0] digits_q,   digits_d;
  logic [7:0]  valid_q,    valid_d;
  logic        frame_q,    frame_d;
  logic [7:0]  err_cnt_q,  err_cnt_d;
  logic        bad_seg_q,  bad_seg_d;
  logic [7:0]  mask_q,     mask_d;

  logic        dp_same;
  logic        same;
  logic        commit;
  logic [3:0]  zero_cnt;
  logic [2:0]  an_idx;
  an_class_e   an_class;
  logic [4:0]  glyph;
  logic [7:0]  mask_set;

`ifdef SEG_SCAN_CAPTURE_DP_EN
  logic        samp_dp_q,  samp_dp_d;
  logic [7:0]  dp_out_q,   dp_out_d;
  assign dp_same = (DP == samp_dp_q);
`else
  // The decimal point plays no part in this build.
  logic unused_dp;
  assign unused_dp = DP;
  assign dp_same   = 1'b1;
`endif

  assign same   = (AN == samp_an_q) && (SEG == samp_seg_q) && dp_same;
  // Commit exactly once per window: the edge that moves the counter onto its ceiling.
  assign commit = same && (cnt_q == COMMIT_AT);
  assign glyph  = decode_glyph(samp_seg_q);

  always_comb begin
    zero_cnt = '0;
    an_idx   = '0;
    for (int k = 0; k < 8; k++) begin
      if (!samp_an_q[k]) begin
        zero_cnt = zero_cnt + 4'd1;
        an_idx   = 3'(k);
      end
    end
    if (zero_cnt == 4'd0)      an_class = AN_IDLE;
    else if (zero_cnt == 4'd1) an_class = AN_SINGLE;
    else                       an_class = AN_ILLEGAL;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    samp_an_d  = AN;
    samp_seg_d = SEG;
    cnt_d      = cnt_q;
    digits_d   = digits_q;
    valid_d    = valid_q;
    frame_d    = 1'b0;
    err_cnt_d  = err_cnt_q;
    bad_seg_d  = bad_seg_q;
    mask_d     = mask_q;
    mask_set   = mask_q;
`ifdef SEG_SCAN_CAPTURE_DP_EN
    samp_dp_d  = DP;
    dp_out_d   = dp_out_q;
`endif

    if (!same)                  cnt_d = '0;
    else if (cnt_q != STABLE_MAX) cnt_d = cnt_q + 8'd1;

    if (commit) begin
      unique case (an_class)
        AN_SINGLE: begin
          mask_set = mask_q | (8'd1 << an_idx);
          if (glyph[4]) begin
            digits_d[{an_idx, 2'b00} +: 4] = glyph[3:0];
            valid_d[an_idx]                = 1'b1;
          end else begin
            valid_d[an_idx] = 1'b0;
            bad_seg_d       = 1'b1;
          end
`ifdef SEG_SCAN_CAPTURE_DP_EN
          dp_out_d[an_idx] = ~samp_dp_q;
`endif
          // The completing commit counts its own bit, pulses, and starts a fresh frame.
          if (&mask_set) begin
            frame_d = 1'b1;
            mask_d  = '0;
          end else begin
            mask_d  = mask_set;
          end
        end
        AN_ILLEGAL: begin
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_an_q  <= 8'hFF;
      samp_seg_q <= 7'h7F;
      cnt_q      <= '0;
      digits_q   <= '0;
      valid_q    <= '0;
      frame_q    <= 1'b0;
      err_cnt_q  <= '0;
      bad_seg_q  <= 1'b0;
      mask_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      samp_an_q  <= samp_an_d;
      samp_seg_q <= samp_seg_d;
      cnt_q      <= cnt_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      frame_q    <= frame_d;
      err_cnt_q  <= err_cnt_d;
      bad_seg_q  <= bad_seg_d;
      mask_q     <= mask_d;
    end
  end

`ifdef SEG_SCAN_CAPTURE_DP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_dp_q <= 1'b1;
      dp_out_q  <= '0;
    end else begin
      samp_dp_q <= samp_dp_d;
      dp_out_q  <= dp_out_d;
    end
  end
  assign DP_OUT = dp_out_q;
`else
  assign DP_OUT = 8'h00;
`endif

  assign DIGITS  = digits_q;
  assign VALID   = valid_q;
  assign FRAME   = frame_q;
  assign ERR_CNT = err_cnt_q;
  assign BAD_SEG = bad_seg_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: behavioural window model compared every cycle, plus literal checks.
module tb_seg_scan_capture;

  localparam int S = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  an    = 8'hFF;
  logic [6:0]  seg   = 7'h7F;
  logic        dp    = 1'b1;
  logic [31:0] DIGITS;
  logic [7:0]  VALID;
  logic [7:0]  DP_OUT;
  logic        FRAME;
  logic [7:0]  ERR_CNT;
  logic        BAD_SEG;

  seg_scan_capture #(.STABLE_CYCLES(S)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .AN     (an),
    .SEG    (seg),
    .DP     (dp),
    .DIGITS (DIGITS),
    .VALID  (VALID),
    .DP_OUT (DP_OUT),
    .FRAME  (FRAME),
    .ERR_CNT(ERR_CNT),
    .BAD_SEG(BAD_SEG)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: a pattern commits when it has been the sampled pattern for exactly S edges.
  int unsigned m_edge = 0;
  int unsigned m_start = 0;
  logic [15:0] m_prev;
  logic [3:0]  m_dig [8];
  logic [7:0]  m_valid, m_dpo, m_err, m_mask;
  logic        m_bad, m_frame;

  function automatic logic dp_seen(input logic d);
`ifdef SEG_SCAN_CAPTURE_DP_EN
    return d;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] m_digits();
    logic [31:0] r = '0;
    for (int k = 0; k < 8; k++) r[4*k +: 4] = m_dig[k];
    return r;
  endfunction

  task automatic model_reset();
    m_prev  = {8'hFF, 7'h7F, 1'b1};
    m_start = m_edge;
    for (int k = 0; k < 8; k++) m_dig[k] = 4'h0;
    m_valid = '0; m_dpo = '0; m_err = '0; m_mask = '0;
    m_bad   = 1'b0; m_frame = 1'b0;
  endtask

  task automatic model_commit();
    logic [7:0] a = m_prev[15:8];
    logic [6:0] s = m_prev[7:1];
    int zeros = 0;
    int idx   = 0;
    int hit   = -1;
    for (int k = 0; k < 8; k++) if (!a[k]) begin zeros++; idx = k; end
    if (zeros == 1) begin
      for (int v = 0; v < 16; v++) if (glyph[v] == s) hit = v;
      if (hit >= 0) begin
        m_dig[idx]   = hit[3:0];
        m_valid[idx] = 1'b1;
      end else begin
        m_valid[idx] = 1'b0;
        m_bad        = 1'b1;
      end
`ifdef SEG_SCAN_CAPTURE_DP_EN
      m_dpo[idx] = ~m_prev[0];
`endif
      m_mask[idx] = 1'b1;
      if (m_mask == 8'hFF) begin
        m_frame = 1'b1;
        m_mask  = '0;
      end
    end else if (zeros > 1) begin
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_edge++;
      m_frame = 1'b0;
      if ({an, seg, dp_seen(dp)} != m_prev) begin
        m_prev  = {an, seg, dp_seen(dp)};
        m_start = m_edge;
      end else if (m_edge - m_start == S) begin
        model_commit();
      end
    end
  end

  bit chk_on = 1'b0;
  int frame_seen = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_DIGITS",  DIGITS,  m_digits());
      check("cyc_VALID",   {24'h0, VALID},   {24'h0, m_valid});
      check("cyc_DP_OUT",  {24'h0, DP_OUT},  {24'h0, m_dpo});
      check("cyc_FRAME",   {31'h0, FRAME},   {31'h0, m_frame});
      check("cyc_ERR_CNT", {24'h0, ERR_CNT}, {24'h0, m_err});
      check("cyc_BAD_SEG", {31'h0, BAD_SEG}, {31'h0, m_bad});
      if (FRAME) frame_seen++;
    end
  end

  task automatic hold(input logic [7:0] a, input logic [6:0] s, input logic d, input int n);
    an = a; seg = s; dp = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_DIGITS"},  DIGITS, 32'h0);
    check({tag, "_VALID"},   {24'h0, VALID}, 32'h0);
    check({tag, "_DP_OUT"},  {24'h0, DP_OUT}, 32'h0);
    check({tag, "_FRAME"},   {31'h0, FRAME}, 32'h0);
    check({tag, "_ERR_CNT"}, {24'h0, ERR_CNT}, 32'h0);
    check({tag, "_BAD_SEG"}, {31'h0, BAD_SEG}, 32'h0);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int f0;
    logic [7:0] a;
    logic [6:0] s;
    int r;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    check_all_zero("reset");

    // First commit lands on the S-th edge after the pattern is first sampled.
    hold(8'hFE, 7'h30, 1'b1, S);
    check("pre_commit_VALID", {24'h0, VALID}, 32'h0);
    hold(8'hFE, 7'h30, 1'b1, 1);
    check("first_DIGIT0", {28'h0, DIGITS[3:0]}, 32'h3);
    check("first_VALID", {24'h0, VALID}, 32'h01);
    check("first_FRAME", {31'h0, FRAME}, 32'h0);
    check("first_ERR", {24'h0, ERR_CNT}, 32'h0);

    f0 = frame_seen;
    for (int d = 0; d < 8; d++) begin
      a = ~(8'd1 << d);
      hold(a, glyph[d], 1'b1, 6);
    end
    check("scan_DIGITS", DIGITS, 32'h76543210);
    check("scan_VALID", {24'h0, VALID}, 32'hFF);
    check("scan_frames", frame_seen - f0, 32'd1);

    hold(8'hFC, 7'h78, 1'b1, 5);
    check("illegal_ERR", {24'h0, ERR_CNT}, 32'h1);
    hold(8'hFF, 7'h7F, 1'b1, 10);
    check("idle_ERR", {24'h0, ERR_CNT}, 32'h1);
    check("idle_DIGITS", DIGITS, 32'h76543210);

    hold(8'hFB, 7'h7F, 1'b1, 5);
    check("badseg_VALID", {24'h0, VALID}, 32'hFB);
    check("badseg_DIGIT2", {28'h0, DIGITS[11:8]}, 32'h2);
    check("badseg_flag", {31'h0, BAD_SEG}, 32'h1);

    for (int k = 0; k < 10; k++) hold(8'hFE, (k % 2 == 0) ? 7'h40 : 7'h79, 1'b1, 2);
    check("glitch_VALID", {24'h0, VALID}, 32'hFB);
    check("glitch_DIGITS", DIGITS, 32'h76543210);
    hold(8'hFE, 7'h79, 1'b1, 5);
    check("settle_DIGITS", DIGITS, 32'h76543211);
    check("badseg_sticky", {31'h0, BAD_SEG}, 32'h1);

    for (int k = 0; k < 130; k++) begin
      hold(8'h00, 7'h00, 1'b1, 5);
      hold(8'hFC, 7'h00, 1'b1, 5);
    end
    check("err_saturate", {24'h0, ERR_CNT}, 32'hFF);

    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      a = ~(8'd1 << $urandom_range(0, 7));
      else if (r < 7) a = 8'hFF;
      else            a = 8'($urandom);
      s = ($urandom_range(0, 3) != 0) ? glyph[$urandom_range(0, 15)] : 7'($urandom);
      hold(a, s, 1'($urandom), $urandom_range(1, 8));
      if ($urandom_range(0, 49) == 0) pulse_reset();
    end

    pulse_reset();
    hold(8'h7F, 7'h00, 1'b0, 5);
    check("dp_DIGIT7", {28'h0, DIGITS[31:28]}, 32'h8);
    check("dp_VALID", {24'h0, VALID}, 32'h80);
`ifdef SEG_SCAN_CAPTURE_DP_EN
    check("dp_DP_OUT", {24'h0, DP_OUT}, 32'h80);
`else
    check("dp_DP_OUT", {24'h0, DP_OUT}, 32'h00);
`endif

    pulse_reset();
    hold(8'h7F, 7'h00, 1'b0, 3);
    pulse_reset();
    hold(8'h7F, 7'h00, 1'b0, S);
    check_all_zero("abort");
    hold(8'h7F, 7'h00, 1'b0, 1);
    check("rewindow_DIGITS", DIGITS, 32'h80000000);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
